// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: data word, ALU opcode and
// arbiter FSM state.
// Imported by alu_arbiter and alu_arbiter_alu.
package alu_arbiter_pkg;

  localparam int WORD_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,  // carry = carry-out
    OP_AND   = 3'd1,
    OP_OR    = 3'd2,
    OP_SUB   = 3'd3,  // carry = borrow (A < B)
    OP_XOR   = 3'd4,
    OP_SHL   = 3'd5,  // carry = bit shifted out of the MSB
    OP_SHR   = 3'd6,  // carry = bit shifted out of the LSB
    OP_PASSB = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 4-bit ALU with carry and zero flags.
// Ports: opcode, a, b in; out, carry, zero out. Zero latency, no flow control.
// Logic ops always report carry=0; zero reflects the 4-bit result only.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  opcode_t opcode,
  input  word_t   a,
  input  word_t   b,
  output word_t   out,
  output logic    carry,
  output logic    zero
);

  // One extra bit on top carries the flag for every opcode.
  logic [WORD_W:0] wide;

  always_comb begin
    wide = '0;
    case (opcode)
      OP_ADD:   wide = {1'b0, a} + {1'b0, b};
      OP_AND:   wide = {1'b0, a & b};
      OP_OR:    wide = {1'b0, a | b};
      // Wrap-around of the 5-bit difference leaves the borrow in the top bit.
      OP_SUB:   wide = {1'b0, a} - {1'b0, b};
      OP_XOR:   wide = {1'b0, a ^ b};
      OP_SHL:   wide = {a, 1'b0};
      OP_SHR:   wide = {a[0], 1'b0, a[WORD_W-1:1]};
      OP_PASSB: wide = {1'b0, b};
      default:  wide = '0;
    endcase
  end

  assign out   = wide[WORD_W-1:0];
  assign carry = wide[WORD_W];
  assign zero  = (wide[WORD_W-1:0] == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Latency: accept in cycle N, registered result valid in N+2; one op per 3 cycles.
// Backpressure: reqN_ready only in IDLE for the granted requester; the result
// holds in RESP until rsp_ready, and no new request is accepted meanwhile.
// Ports: clk, reset (sync, active high); reqN_valid/opcode/a/b in, reqN_ready
// out; rsp_valid/id/out/carry/zero out, rsp_ready in.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_opcode,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_opcode,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_out,
  output logic       rsp_carry,
  output logic       rsp_zero,
  input  logic       rsp_ready
);

  state_t  state, state_nxt;
  logic    prio;        // requester that wins when both are valid
  logic    grant_any;
  logic    grant_id;

  opcode_t op_q;
  word_t   a_q, b_q;
  logic    id_q;

  word_t   alu_out;
  logic    alu_carry, alu_zero;

  // The ALU only ever sees the captured operands, so input wiggles after
  // accept cannot leak into the result.
  alu_arbiter_alu u_alu (
    .opcode (op_q),
    .a      (a_q),
    .b      (b_q),
    .out    (alu_out),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_any  = 1'b0;
    grant_id   = prio;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        // Gate with reset so ready stays low while reset is asserted.
        if (!reset) begin
          if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = prio;
          end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
          end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
          end
        end
        req0_ready = grant_any && !grant_id;
        req1_ready = grant_any &&  grant_id;
        if (grant_any) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio      <= RR_INIT;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      if (state == ST_IDLE && grant_any) begin
        id_q <= grant_id;
        op_q <= grant_id ? opcode_t'(req1_opcode) : opcode_t'(req0_opcode);
        a_q  <= grant_id ? req1_a : req0_a;
        b_q  <= grant_id ? req1_b : req0_b;
      end
      if (state == ST_EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_out   <= alu_out;
        rsp_carry <= alu_carry;
        rsp_zero  <= alu_zero;
      end
      if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        // Hand priority to the requester that was not just served.
        prio      <= ~rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed latency/hold/reset scenarios followed by
// randomized two-requester traffic scored against an arithmetic ALU model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_opcode = '0, req1_opcode = '0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       rsp_ready = 1'b0;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_carry, rsp_zero;
  logic [3:0] rsp_out;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_opcode(req0_opcode),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_opcode(req1_opcode),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic; returns {id, carry, zero, out}.
  function automatic logic [6:0] expect_rsp(input logic id, input logic [2:0] op,
                                            input logic [3:0] a, input logic [3:0] b);
    int ai, bi, r, c;
    ai = int'(a);
    bi = int'(b);
    r  = 0;
    c  = 0;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 15) ? 1 : 0; r = r % 16; end
      3'd1: r = ai & bi;
      3'd2: r = ai | bi;
      3'd3: begin r = ai - bi; c = (r < 0) ? 1 : 0; r = (r + 16) % 16; end
      3'd4: r = ai ^ bi;
      3'd5: begin r = ai * 2; c = (r > 15) ? 1 : 0; r = r % 16; end
      3'd6: begin r = ai / 2; c = ai % 2; end
      default: r = bi;
    endcase
    return {id, c[0], (r == 0), r[3:0]};
  endfunction

  function automatic logic [7:0] rsp_bus();
    return {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_out};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  // Leaves priority pointing at req1, then resets with an op in EXEC (stage 1)
  // or RESP (stage 2) and checks the op vanishes and priority is back to 0.
  task automatic mid_reset(input int stage, input string tag);
    do_reset();
    req0_valid = 1'b1; req0_opcode = 3'd0; req0_a = 4'd1; req0_b = 4'd2; rsp_ready = 1'b1;
    cyc(); req0_valid = 1'b0;
    cyc();
    cyc();
    req0_valid = 1'b1; req0_opcode = 3'd4; req0_a = 4'd5; req0_b = 4'd6; rsp_ready = 1'b0;
    cyc(); req0_valid = 1'b0;
    if (stage == 2) cyc();
    smp();
    check_eq({tag, "_pre"}, rsp_valid, (stage == 2) ? 1 : 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rsp_ready = 1'b1;
    smp();
    check_eq({tag, "_zero"}, rsp_bus(), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      check_eq({tag, "_norsp"}, rsp_valid, 0);
    end
    cyc();
    req0_valid = 1'b1; req1_valid = 1'b1;
    smp();
    check_eq({tag, "_prio"}, {req0_ready, req1_ready}, 2'b10);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic new_op(output logic [2:0] op, output logic [3:0] a, output logic [3:0] b);
    op = 3'($urandom);
    a  = 4'($urandom);
    b  = 4'($urandom);
  endtask

  logic [6:0] exp_q[$];
  logic [6:0] e;
  logic [6:0] e0;
  logic       model_prio;
  logic       acc0, acc1;
  int         n_rsp;
  int         g;
  int         order[3];

  initial begin
    // Reset state, ready held low while reset is asserted even with valids up.
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      smp();
      check_eq("rst_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    smp();
    check_eq("rst_rsp", rsp_bus(), 0);

    // Single op, latency, operand capture, hold under backpressure.
    cyc();
    req0_valid = 1'b1; req0_opcode = 3'b011; req0_a = 4'b0011; req0_b = 4'b0011;
    smp();
    check_eq("acc_ready", {req0_ready, req1_ready}, 2'b10);
    cyc();
    req0_valid = 1'b0; req0_a = 4'b1001; req0_b = 4'b1010;
    req1_valid = 1'b1; req1_opcode = 3'd0; req1_a = 4'd9; req1_b = 4'd8;
    smp();
    check_eq("exec_idle", {rsp_valid, req1_ready}, 0);
    cyc();
    smp();
    e0 = expect_rsp(1'b0, 3'b011, 4'b0011, 4'b0011);
    check_eq("lat_rsp", rsp_bus(), {1'b1, e0});
    for (int i = 0; i < 5; i++) begin
      cyc(); smp();
      check_eq($sformatf("hold%0d", i), {rsp_bus(), req0_ready, req1_ready}, {1'b1, e0, 2'b00});
    end
    cyc(); rsp_ready = 1'b1;
    smp();
    check_eq("release", {rsp_valid, req1_ready}, 2'b10);
    cyc(); rsp_ready = 1'b0;
    smp();
    check_eq("idle_after", {rsp_valid, req0_ready, req1_ready}, 3'b001);
    cyc(); req1_valid = 1'b0; rsp_ready = 1'b1;
    cyc(); smp();
    check_eq("r1_rsp", rsp_bus(), {1'b1, expect_rsp(1'b1, 3'd0, 4'd9, 4'd8)});
    cyc(); rsp_ready = 1'b0;

    // Round-robin with both requesters permanently valid.
    do_reset();
    req0_valid = 1'b1; req0_opcode = 3'd2; req0_a = 4'd3; req0_b = 4'd4;
    req1_valid = 1'b1; req1_opcode = 3'd1; req1_a = 4'd7; req1_b = 4'd5;
    rsp_ready = 1'b1;
    g = 0;
    order[0] = -1; order[1] = -1; order[2] = -1;
    for (int t = 0; t < 40 && g < 3; t++) begin
      smp();
      if (req0_ready || req1_ready) begin
        order[g] = req1_ready ? 1 : 0;
        g++;
      end
      cyc();
    end
    check_eq("rr_count", g, 3);
    check_eq("rr_g0", order[0], 0);
    check_eq("rr_g1", order[1], 1);
    check_eq("rr_g2", order[2], 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) cyc();

    mid_reset(1, "rst_exec");
    mid_reset(2, "rst_resp");

    // Random traffic against the reference model.
    do_reset();
    model_prio = 1'b0;
    n_rsp = 0;
    for (int t = 0; t < 4000; t++) begin
      smp();
      check_eq("ready_excl", {31'd0, req0_ready & req1_ready}, 0);
      check_eq("ready_valid", {31'd0, (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)}, 0);
      acc0 = req0_ready;
      acc1 = req1_ready;
      if (acc0 || acc1) begin
        if (req0_valid && req1_valid) check_eq("rr_prio", acc1, model_prio);
        if (acc1) exp_q.push_back(expect_rsp(1'b1, req1_opcode, req1_a, req1_b));
        else      exp_q.push_back(expect_rsp(1'b0, req0_opcode, req0_a, req0_b));
      end
      if (rsp_valid && rsp_ready) begin
        check_eq("rsp_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("rsp_data", {rsp_id, rsp_carry, rsp_zero, rsp_out}, e);
          model_prio = ~e[6];
          n_rsp++;
        end
      end
      cyc();
      if (t >= 3980) begin
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      end else begin
        if (acc0) begin
          req0_valid = ($urandom % 4) != 0;
          new_op(req0_opcode, req0_a, req0_b);
        end else if (!req0_valid) begin
          if ($urandom % 3 == 0) begin
            req0_valid = 1'b1;
            new_op(req0_opcode, req0_a, req0_b);
          end
        end else if ($urandom % 10 == 0) begin
          req0_valid = 1'b0;
        end
        if (acc1) begin
          req1_valid = ($urandom % 4) != 0;
          new_op(req1_opcode, req1_a, req1_b);
        end else if (!req1_valid) begin
          if ($urandom % 3 == 0) begin
            req1_valid = 1'b1;
            new_op(req1_opcode, req1_a, req1_b);
          end
        end else if ($urandom % 10 == 0) begin
          req1_valid = 1'b0;
        end
        rsp_ready = ($urandom % 4) != 0;
      end
    end
    check_eq("drain", exp_q.size(), 0);
    check_eq("rsp_volume", (n_rsp > 100) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
